// File: rtl/cmd_flag_latch.sv
// cmd_flag_latch: bank of set/reset command flags driven by synchronized,
// edge-detected Set/Reset requests, with change pulses and a sticky overrun.
`default_nettype none

module cmd_flag_latch #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] Set,
  input  logic [WIDTH-1:0] Reset,
  output logic [WIDTH-1:0] Flag,
  output logic [WIDTH-1:0] FlagRise,
  output logic [WIDTH-1:0] FlagFall,
  output logic [WIDTH-1:0] Overrun,
  output logic             AnyFlag
);

  logic [WIDTH-1:0] s_set;
  logic [WIDTH-1:0] s_reset;
  logic [WIDTH-1:0] prev_set;
  logic [WIDTH-1:0] prev_reset;
  logic [WIDTH-1:0] set_edge;
  logic [WIDTH-1:0] rst_edge;
  logic [WIDTH-1:0] flag_next;
  logic [WIDTH-1:0] overrun_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_set   = Set;
      assign s_reset = Reset;
    end else begin : g_sync
      logic [WIDTH-1:0] set_pipe [SYNC_STAGES];
      logic [WIDTH-1:0] rst_pipe [SYNC_STAGES];

      always_ff @(posedge Clock) begin
        if (!ResetN) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            set_pipe[i] <= '0;
            rst_pipe[i] <= '0;
          end
        end else begin
          set_pipe[0] <= Set;
          rst_pipe[0] <= Reset;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            set_pipe[i] <= set_pipe[i-1];
            rst_pipe[i] <= rst_pipe[i-1];
          end
        end
      end

      assign s_set   = set_pipe[SYNC_STAGES-1];
      assign s_reset = rst_pipe[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      prev_set   <= '0;
      prev_reset <= '0;
    end else begin
      prev_set   <= s_set;
      prev_reset <= s_reset;
    end
  end

  always_comb begin
    set_edge     = s_set & ~prev_set;
    rst_edge     = s_reset & ~prev_reset;
    // Set beats a coincident reset so a new request is never dropped.
    flag_next    = set_edge | (Flag & ~rst_edge);
    overrun_next = (set_edge & Flag) | (Overrun & ~(rst_edge & ~set_edge));
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      Flag     <= '0;
      FlagRise <= '0;
      FlagFall <= '0;
      Overrun  <= '0;
    end else begin
      Flag     <= flag_next;
      FlagRise <= flag_next & ~Flag;
      FlagFall <= ~flag_next & Flag;
      Overrun  <= overrun_next;
    end
  end

  assign AnyFlag = |Flag;

endmodule

`default_nettype wire

// File: tb/tb_cmd_flag_latch.sv
// Directed bench: lane tests on a 1-bit/2-stage instance, multi-lane on a 4-bit/0-stage instance.
`default_nettype none

module tb_cmd_flag_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a_set, a_reset;
  logic [0:0] a_flag, a_rise, a_fall, a_ovr;
  logic       a_any;
  logic [3:0] b_set, b_reset;
  logic [3:0] b_flag, b_rise, b_fall, b_ovr;
  logic       b_any;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int n_rise;
  int n_fall;

  always #5 clk = ~clk;

  cmd_flag_latch #(.WIDTH(1), .SYNC_STAGES(2)) dut_a (
    .Clock(clk), .ResetN(rst_n), .Set(a_set), .Reset(a_reset),
    .Flag(a_flag), .FlagRise(a_rise), .FlagFall(a_fall),
    .Overrun(a_ovr), .AnyFlag(a_any)
  );

  cmd_flag_latch #(.WIDTH(4), .SYNC_STAGES(0)) dut_b (
    .Clock(clk), .ResetN(rst_n), .Set(b_set), .Reset(b_reset),
    .Flag(b_flag), .FlagRise(b_rise), .FlagFall(b_fall),
    .Overrun(b_ovr), .AnyFlag(b_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; a_set = '0; a_reset = '0; b_set = '0; b_reset = '0;
    cyc(2);
    chk("rst_flag",    {31'd0, a_flag}, 32'd0);
    chk("rst_rise",    {31'd0, a_rise}, 32'd0);
    chk("rst_fall",    {31'd0, a_fall}, 32'd0);
    chk("rst_ovr",     {31'd0, a_ovr},  32'd0);
    chk("rst_any",     {31'd0, a_any},  32'd0);
    chk("rst_b_flag",  {28'd0, b_flag}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Basic set: 1-cycle pulse, flag appears after the third edge
    a_set = 1'b1;
    cyc(1); a_set = 1'b0;
    chk("set_e0_flag", {31'd0, a_flag}, 32'd0);
    cyc(1);
    chk("set_e1_flag", {31'd0, a_flag}, 32'd0);
    cyc(1);
    chk("set_e2_flag", {31'd0, a_flag}, 32'd1);
    chk("set_e2_rise", {31'd0, a_rise}, 32'd1);
    chk("set_e2_any",  {31'd0, a_any},  32'd1);
    cyc(1);
    chk("set_e3_rise", {31'd0, a_rise}, 32'd0);
    chk("set_e3_flag", {31'd0, a_flag}, 32'd1);

    // Basic clear
    a_reset = 1'b1;
    cyc(1); a_reset = 1'b0;
    chk("clr_e0_flag", {31'd0, a_flag}, 32'd1);
    cyc(1);
    chk("clr_e1_flag", {31'd0, a_flag}, 32'd1);
    cyc(1);
    chk("clr_e2_flag", {31'd0, a_flag}, 32'd0);
    chk("clr_e2_fall", {31'd0, a_fall}, 32'd1);
    cyc(1);
    chk("clr_e3_fall", {31'd0, a_fall}, 32'd0);
    cyc(2);

    // Held levels give exactly one edge each
    n_rise = 0;
    a_set = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(1); n_rise += int'(a_rise); end
    a_set = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(1); n_rise += int'(a_rise); end
    chk("held_set_rises", n_rise, 32'd1);
    chk("held_set_flag",  {31'd0, a_flag}, 32'd1);
    n_fall = 0;
    a_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(1); n_fall += int'(a_fall); end
    a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(1); n_fall += int'(a_fall); end
    chk("held_rst_falls", n_fall, 32'd1);
    chk("held_rst_flag",  {31'd0, a_flag}, 32'd0);

    // Simultaneous set/reset with Flag=0: set wins, no overrun
    a_set = 1'b1; a_reset = 1'b1;
    cyc(1); a_set = 1'b0; a_reset = 1'b0;
    cyc(2);
    chk("sim0_flag", {31'd0, a_flag}, 32'd1);
    chk("sim0_ovr",  {31'd0, a_ovr},  32'd0);
    cyc(3);

    // Simultaneous with Flag=1: flag holds, overrun sets, no rise
    n_rise = 0;
    a_set = 1'b1; a_reset = 1'b1;
    cyc(1); a_set = 1'b0; a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(1); n_rise += int'(a_rise); end
    chk("sim1_flag",  {31'd0, a_flag}, 32'd1);
    chk("sim1_ovr",   {31'd0, a_ovr},  32'd1);
    chk("sim1_rises", n_rise, 32'd0);

    // Lone reset clears both flag and overrun
    a_reset = 1'b1;
    cyc(1); a_reset = 1'b0;
    cyc(1);
    chk("lone_e1_ovr", {31'd0, a_ovr},  32'd1);
    cyc(1);
    chk("lone_flag",   {31'd0, a_flag}, 32'd0);
    chk("lone_ovr",    {31'd0, a_ovr},  32'd0);
    cyc(3);

    // Multi-lane, no synchronizer: one-edge latency
    b_set = 4'b0101;
    cyc(1); b_set = 4'b0000;
    chk("b_set_flag", {28'd0, b_flag}, 32'h5);
    chk("b_set_rise", {28'd0, b_rise}, 32'h5);
    chk("b_set_any",  {31'd0, b_any},  32'd1);
    b_reset = 4'b0001;
    cyc(1); b_reset = 4'b0000;
    chk("b_clr_flag", {28'd0, b_flag}, 32'h4);
    chk("b_clr_fall", {28'd0, b_fall}, 32'h1);
    chk("b_clr_any",  {31'd0, b_any},  32'd1);
    b_set = 4'b0100;
    cyc(1); b_set = 4'b0000;
    chk("b_ovr",      {28'd0, b_ovr},  32'h4);
    chk("b_ovr_rise", {28'd0, b_rise}, 32'h0);
    chk("b_ovr_flag", {28'd0, b_flag}, 32'h4);

    // Reset mid-operation with Set held high
    a_set = 1'b1;
    cyc(4);
    chk("mid_pre_flag", {31'd0, a_flag}, 32'd1);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_flag", {31'd0, a_flag}, 32'd0);
    chk("mid_rst_ovr",  {31'd0, a_ovr},  32'd0);
    chk("mid_rst_any",  {31'd0, a_any},  32'd0);
    chk("mid_rst_bflg", {28'd0, b_flag}, 32'h0);
    chk("mid_rst_bovr", {28'd0, b_ovr},  32'h0);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_e0_flag", {31'd0, a_flag}, 32'd0);
    cyc(1);
    chk("rel_e1_flag", {31'd0, a_flag}, 32'd0);
    cyc(1);
    chk("rel_e2_flag", {31'd0, a_flag}, 32'd1);
    chk("rel_e2_rise", {31'd0, a_rise}, 32'd1);
    a_set = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
